// File: rtl/connect_send_adapter.sv
// rtl/connect_send_adapter.sv - credit-aware packetizer feeding one CONNECT network send port
module connect_send_adapter #(
  parameter int FLIT_DATA_WIDTH = 32,
  parameter int DEST_BITS       = 2,
  parameter int VC_BITS         = 1,
  parameter int NUM_VCS         = 2,
  parameter int CREDITS_PER_VC  = 8,
  localparam int FLIT_W         = 2 + FLIT_DATA_WIDTH + DEST_BITS + VC_BITS,
  localparam int CNT_W          = $clog2(CREDITS_PER_VC + 1)
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       msg_valid,
  output logic                       msg_ready,
  input  logic [FLIT_DATA_WIDTH-1:0] msg_data,
  input  logic                       msg_last,
  input  logic [DEST_BITS-1:0]       msg_dest,
  input  logic [VC_BITS-1:0]         msg_vc,
  output logic [FLIT_W-1:0]          flit_out,
  output logic                       flit_en,
  input  logic [VC_BITS:0]           credit_in,
  output logic                       busy,
  output logic [15:0]                pkt_sent,
  output logic                       err_credit_ovf
);

  typedef enum logic {S_IDLE, S_BODY} state_t;

  state_t               state, state_nxt;
  logic [DEST_BITS-1:0] dest_q;
  logic [VC_BITS-1:0]   vc_q;
  logic [CNT_W-1:0]     credit     [NUM_VCS];
  logic [CNT_W-1:0]     credit_nxt [NUM_VCS];
  logic [VC_BITS-1:0]   sel_vc;
  logic [DEST_BITS-1:0] sel_dest;
  logic                 xfer;
  logic                 ovf_now;
  logic                 ret_valid;
  logic [VC_BITS-1:0]   ret_vc;

  assign sel_vc    = (state == S_IDLE) ? msg_vc : vc_q;
  assign sel_dest  = (state == S_IDLE) ? msg_dest : dest_q;
  assign xfer      = msg_valid & msg_ready;
  assign ret_valid = credit_in[VC_BITS];
  assign ret_vc    = credit_in[VC_BITS-1:0];
  assign busy      = (state == S_BODY);

  // A selected VC outside the tracked range never has credit.
  always_comb begin
    msg_ready = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (sel_vc == VC_BITS'(v) && credit[v] != '0) msg_ready = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (xfer && !msg_last) state_nxt = S_BODY;
      S_BODY: if (xfer && msg_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Simultaneous send and return on one VC cancel; a return at full credit is an error.
  always_comb begin
    ovf_now = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      credit_nxt[v] = credit[v];
      if (ret_valid && ret_vc == VC_BITS'(v)) begin
        if (!(xfer && sel_vc == VC_BITS'(v))) begin
          if (credit[v] == CNT_W'(CREDITS_PER_VC)) ovf_now = 1'b1;
          else credit_nxt[v] = credit[v] + CNT_W'(1);
        end
      end else if (xfer && sel_vc == VC_BITS'(v)) begin
        credit_nxt[v] = credit[v] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state          <= S_IDLE;
      dest_q         <= '0;
      vc_q           <= '0;
      flit_en        <= 1'b0;
      flit_out       <= '0;
      pkt_sent       <= '0;
      err_credit_ovf <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CNT_W'(CREDITS_PER_VC);
    end else begin
      state          <= state_nxt;
      flit_en        <= xfer;
      flit_out       <= xfer ? {1'b1, msg_last, sel_dest, sel_vc, msg_data} : '0;
      err_credit_ovf <= err_credit_ovf | ovf_now;
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= credit_nxt[v];
      if (state == S_IDLE && xfer && !msg_last) begin
        dest_q <= msg_dest;
        vc_q   <= msg_vc;
      end
      if (xfer && msg_last) pkt_sent <= pkt_sent + 16'd1;
    end
  end

endmodule

// File: doc/connect_send_adapter.md
# connect_send_adapter

Credit-aware packetizer between a user traffic source and one CONNECT network send port (`send_ports_N_putFlit` / `send_ports_N_getCredits` of `mkNetwork`). It accepts message beats over a valid/ready stream and latches destination and VC on the head beat. It formats each beat as a network flit and issues it only when the target VC has a downstream credit. It consumes the credit tokens returned by the network, so the network-facing side of a send port needs no bench-side flow-control logic.

## Interface
- FLIT_DATA_WIDTH, 32, payload bits per flit
- DEST_BITS, 2, destination field width (clog2 of receive-port count)
- VC_BITS, 1, VC field width (1 even when NUM_VCS==1)
- NUM_VCS, 2, virtual channels tracked
- CREDITS_PER_VC, 8, downstream buffer depth per VC (initial credit)
- Derived: FLIT_W = 2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS; CNT_W = clog2(CREDITS_PER_VC+1)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- msg_valid  in  1  source has a beat
- msg_ready  out  1  adapter accepts the beat this cycle
- msg_data  in  FLIT_DATA_WIDTH  beat payload
- msg_last  in  1  beat is the packet tail
- msg_dest  in  DEST_BITS  destination; sampled on head beat only
- msg_vc  in  VC_BITS  VC; sampled on head beat only
- flit_out  out  FLIT_W  {valid, tail, dest, vc, data}, MSB first; drives putFlit_flit_in
- flit_en  out  1  drives EN_send_ports_N_putFlit
- credit_in  in  1+VC_BITS  {valid, vc} from getCredits; EN_getCredits tied 1 at the top level
- busy  out  1  a packet is open (head sent, tail not yet sent)
- pkt_sent  out  16  count of tail flits issued; wraps
- err_credit_ovf  out  1  sticky; a credit was returned to a VC already at CREDITS_PER_VC

## Operation
- Two-state FSM: IDLE (expecting a head beat) and BODY (packet open).
  - IDLE, beat accepted with msg_last=0: latch dest and vc, go to BODY.
  - IDLE, beat accepted with msg_last=1: single-flit packet; stay in IDLE.
  - BODY, beat accepted with msg_last=1: go to IDLE.
- sel_vc = (state==IDLE) ? msg_vc : latched vc.
- sel_dest = (state==IDLE) ? msg_dest : latched dest.
- In BODY, msg_dest and msg_vc are ignored.
- msg_ready = (credit[sel_vc] != 0). This is combinational from state, credit counters and msg_vc. It does not depend on msg_valid.
- Transfer occurs when msg_valid & msg_ready.
- Per-VC credit counter (CNT_W bits):
  - Decrement on a transfer to that VC.
  - Increment when credit_in valid bit=1 for that VC.
  - Both in the same cycle on the same VC: unchanged.
  - Increment at CREDITS_PER_VC: hold the value and set err_credit_ovf.
  - Decrement below 0 cannot occur, because msg_ready gates the transfer.
- A credit_in vc >= NUM_VCS is ignored.
- Packets are never interleaved: a second packet's head is accepted only after the previous tail.
- pkt_sent increments when a tail flit is issued. busy = (state==BODY).

## Timing
- Reset values: state IDLE; credit[v]=CREDITS_PER_VC for all v; flit_en=0; flit_out=0; busy=0; pkt_sent=0; err_credit_ovf=0.
  - msg_ready is 1 after reset while CREDITS_PER_VC>0.
- Reset asserted mid-packet: the open packet is abandoned and credits are restored to CREDITS_PER_VC. The integrator resets the network together with the adapter.
- Flit latency: a transfer at edge k sets flit_out and flit_en=1 during the cycle after edge k. flit_en is a single-cycle pulse per flit.
- On cycles without a transfer, flit_out=0, so the valid bit is 0.
- Throughput: 1 flit per cycle while credits last.
- Credit latency: credit_in sampled at edge k updates the counter at edge k. msg_ready may rise in the cycle following edge k.
- Counter changes from a transfer take effect from the next cycle. There is no bypass, so a beat accepted while credit==1 drives msg_ready to 0 next cycle unless a credit returns in the same cycle.

## Test plan
- Reset for 5 cycles, then check outputs: flit_en=0, flit_out=0, busy=0, pkt_sent=0, msg_ready=1.
- Two-flit packet, dest=1, vc=0, data 0xa then 0xb, back-to-back:
  - flit_out=0x12_0000_000a with flit_en=1 in the cycle after the first transfer.
  - flit_out=0x1A_0000_000b in the next cycle.
  - busy is 1 for exactly one cycle; pkt_sent=1; credit[0]=6.
- Credit exhaustion, no credits returned: offer 9 single-flit packets on vc=0.
  - 8 are issued, then msg_ready=0.
  - After credit_in={1,0} for one cycle, the 9th flit is issued on the following cycle.
- Simultaneous return and send: credit_in={1,0} in the same cycle as a vc0 transfer.
  - credit[0] is unchanged and no stall occurs.
  - A vc1 return in the same cycle increments credit[1] only.
- Head/body sampling: open a packet with dest=2, vc=1, then change msg_dest=3 and msg_vc=0 on body beats.
  - Body flits carry dest=2 and vc=1.
  - Only credit[1] decrements.
- Overflow and reset mid-packet:
  - credit_in={1,1} at full credit sets err_credit_ovf=1 and keeps credit[1]=8.
  - RST_N=0 during BODY clears busy and the error flag and restores both credits to 8.
